// File: rtl/fsm_ctrl.sv
// fsm_ctrl: Moore instruction controller (IR, decode, register-file/datapath strobes).
// Optional CTRL_ILLEGAL_TRAP_EN adds a HALT state and the err output for illegal decodes.
module fsm_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        s,
   input  logic        load,
   input  logic [15:0] in,
   output logic        w,
   output logic [2:0]  writenum,
   output logic [2:0]  readnum,
   output logic        write,
   output logic        loada,
   output logic        loadb,
   output logic        loadc,
   output logic        loads,
   output logic        asel,
   output logic [1:0]  vsel,
   output logic [1:0]  shift,
   output logic [1:0]  ALUop,
   output logic [15:0] sximm8,
   output logic [15:0] sximm5
`ifdef CTRL_ILLEGAL_TRAP_EN
   ,output logic       err
`endif
);

   localparam int unsigned IrW   = 16;
   localparam int unsigned SelW  = 3;
   localparam int unsigned VselW = 2;

   typedef enum logic [2:0] {
      S_WAIT      = 3'd0,
      S_DECODE    = 3'd1,
      S_WRITE_IMM = 3'd2,
      S_GET_A     = 3'd3,
      S_GET_B     = 3'd4,
      S_EXEC      = 3'd5,
      S_WRITE_REG = 3'd6,
      S_HALT      = 3'd7
   } state_e;

   state_e            state_q, state_d;
   logic [IrW-1:0]    ir_q, ir_d;

   logic              w_q, w_d;
   logic              write_q, write_d;
   logic [SelW-1:0]   writenum_q, writenum_d;
   logic [SelW-1:0]   readnum_q, readnum_d;
   logic              loada_q, loada_d;
   logic              loadb_q, loadb_d;
   logic              loadc_q, loadc_d;
   logic              loads_q, loads_d;
   logic              asel_q, asel_d;
   logic [VselW-1:0]  vsel_q, vsel_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
   logic              err_q, err_d;
`endif

   // Instruction class predicates on {opcode, op}
   function automatic logic is_movi(input logic [IrW-1:0] ir);
      return ir[15:11] == 5'b110_10;
   endfunction

   function automatic logic is_movr(input logic [IrW-1:0] ir);
      return ir[15:11] == 5'b110_00;
   endfunction

   function automatic logic is_mvn(input logic [IrW-1:0] ir);
      return ir[15:11] == 5'b101_11;
   endfunction

   function automatic logic is_alu(input logic [IrW-1:0] ir);
      return (ir[15:13] == 3'b101) && (ir[12:11] != 2'b11);
   endfunction

   function automatic logic is_cmp(input logic [IrW-1:0] ir);
      return ir[15:11] == 5'b101_01;
   endfunction

   // Next-state and IR load; IR only accepts new words while waiting
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      case (state_q)
         S_WAIT: begin
            if (load) ir_d = in;
            if (s) state_d = S_DECODE;
         end
         S_DECODE: begin
            if (is_movi(ir_q))                       state_d = S_WRITE_IMM;
            else if (is_movr(ir_q) || is_mvn(ir_q))  state_d = S_GET_B;
            else if (is_alu(ir_q))                   state_d = S_GET_A;
            else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
               state_d = S_HALT;
`else
               state_d = S_WAIT;
`endif
            end
         end
         S_WRITE_IMM: state_d = S_WAIT;
         S_GET_A:     state_d = S_GET_B;
         S_GET_B:     state_d = S_EXEC;
         S_EXEC:      state_d = is_cmp(ir_q) ? S_WAIT : S_WRITE_REG;
         S_WRITE_REG: state_d = S_WAIT;
         S_HALT: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            state_d = S_HALT;
`else
            state_d = S_WAIT;
`endif
         end
         default:     state_d = S_WAIT;
      endcase
   end

   // Moore outputs decoded from the upcoming state so they register alongside it
   always_comb begin
      w_d        = 1'b0;
      write_d    = 1'b0;
      writenum_d = '0;
      readnum_d  = '0;
      loada_d    = 1'b0;
      loadb_d    = 1'b0;
      loadc_d    = 1'b0;
      loads_d    = 1'b0;
      asel_d     = 1'b0;
      vsel_d     = '0;
      case (state_d)
         S_WAIT: w_d = 1'b1;
         S_WRITE_IMM: begin
            write_d    = 1'b1;
            writenum_d = ir_d[10:8];
            vsel_d     = 2'b10;
         end
         S_GET_A: begin
            readnum_d = ir_d[10:8];
            loada_d   = 1'b1;
         end
         S_GET_B: begin
            readnum_d = ir_d[2:0];
            loadb_d   = 1'b1;
         end
         S_EXEC: begin
            asel_d  = is_movr(ir_d);
            loads_d = is_cmp(ir_d);
            loadc_d = !is_cmp(ir_d);
         end
         S_WRITE_REG: begin
            write_d    = 1'b1;
            writenum_d = ir_d[7:5];
            vsel_d     = 2'b00;
         end
         default: ;
      endcase
   end

`ifdef CTRL_ILLEGAL_TRAP_EN
   assign err_d = (state_d == S_HALT);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_WAIT;
         ir_q       <= '0;
         w_q        <= 1'b1;
         write_q    <= 1'b0;
         writenum_q <= '0;
         readnum_q  <= '0;
         loada_q    <= 1'b0;
         loadb_q    <= 1'b0;
         loadc_q    <= 1'b0;
         loads_q    <= 1'b0;
         asel_q     <= 1'b0;
         vsel_q     <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         ir_q       <= ir_d;
         w_q        <= w_d;
         write_q    <= write_d;
         writenum_q <= writenum_d;
         readnum_q  <= readnum_d;
         loada_q    <= loada_d;
         loadb_q    <= loadb_d;
         loadc_q    <= loadc_d;
         loads_q    <= loads_d;
         asel_q     <= asel_d;
         vsel_q     <= vsel_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
         err_q      <= err_d;
`endif
      end
   end

   // Strobes are masked for the whole cycle in which reset is high
   assign write    = write_q & ~reset;
   assign loada    = loada_q & ~reset;
   assign loadb    = loadb_q & ~reset;
   assign loadc    = loadc_q & ~reset;
   assign loads    = loads_q & ~reset;

   assign w        = w_q;
   assign writenum = writenum_q;
   assign readnum  = readnum_q;
   assign asel     = asel_q;
   assign vsel     = vsel_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
   assign err      = err_q;
`endif

   assign sximm8   = {{8{ir_q[7]}}, ir_q[7:0]};
   assign sximm5   = {{11{ir_q[4]}}, ir_q[4:0]};
   assign shift    = ir_q[4:3];
   assign ALUop    = ir_q[12:11];

endmodule

// File: tb/tb_fsm_ctrl.sv
// tb_fsm_ctrl: self-checking bench for fsm_ctrl; per-instruction expected output traces
// are built from the instruction class and compared cycle by cycle.
module tb_fsm_ctrl;

   logic        clk = 1'b0;
   logic        reset, s, load;
   logic [15:0] in;
   logic        w, write, loada, loadb, loadc, loads, asel;
   logic [2:0]  writenum, readnum;
   logic [1:0]  vsel, shift, ALUop;
   logic [15:0] sximm8, sximm5;
`ifdef CTRL_ILLEGAL_TRAP_EN
   logic        err;
`endif

   fsm_ctrl dut (
      .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
      .w(w), .writenum(writenum), .readnum(readnum), .write(write),
      .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel),
      .vsel(vsel), .shift(shift), .ALUop(ALUop), .sximm8(sximm8), .sximm5(sximm5)
`ifdef CTRL_ILLEGAL_TRAP_EN
      ,.err(err)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       err;
      logic       w;
      logic       write;
      logic [2:0] writenum;
      logic [2:0] readnum;
      logic       loada;
      logic       loadb;
      logic       loadc;
      logic       loads;
      logic       asel;
      logic [1:0] vsel;
   } obs_t;

   int   n_checks = 0;
   int   n_errors = 0;
   obs_t exp_q[$];
   obs_t msk_q[$];

   function automatic obs_t sample();
      obs_t o;
      o = '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      o.err = err;
`endif
      o.w = w; o.write = write; o.writenum = writenum; o.readnum = readnum;
      o.loada = loada; o.loadb = loadb; o.loadc = loadc; o.loads = loads;
      o.asel = asel; o.vsel = vsel;
      return o;
   endfunction

   // Immediates, shift and ALUop expected straight from the instruction word
   function automatic logic [35:0] imm_model(input logic [15:0] ir);
      logic [7:0] i8;
      logic [4:0] i5;
      i8 = ir[7:0];
      i5 = ir[4:0];
      return {16'($signed(i8)), 16'($signed(i5)), ir[4:3], ir[12:11]};
   endfunction

   // asel only matters in the execute step, vsel only while writing
   task automatic push(input obs_t e, input bit exec_step);
      obs_t m;
      m = '1;
      if (!exec_step) m.asel = 1'b0;
      if (!e.write)   m.vsel = 2'b00;
      exp_q.push_back(e);
      msk_q.push_back(m);
   endtask

   // Trace of outputs for each cycle after the s-sampling edge, ending back in WAIT
   task automatic build_expect(input logic [15:0] ir);
      logic [2:0] opc, rn, rd, rm;
      logic [1:0] op;
      obs_t idle, done, e;
      opc = ir[15:13]; op = ir[12:11]; rn = ir[10:8]; rd = ir[7:5]; rm = ir[2:0];
      exp_q.delete();
      msk_q.delete();
      idle = '0;
      done = '0;
      done.w = 1'b1;
      push(idle, 1'b0);
      if (opc == 3'b110 && op == 2'b10) begin
         e = idle; e.write = 1'b1; e.writenum = rn; e.vsel = 2'b10; push(e, 1'b0);
         push(done, 1'b0);
      end else if ((opc == 3'b110 && op == 2'b00) || (opc == 3'b101 && op == 2'b11)) begin
         e = idle; e.readnum = rm; e.loadb = 1'b1; push(e, 1'b0);
         e = idle; e.loadc = 1'b1; e.asel = (opc == 3'b110); push(e, 1'b1);
         e = idle; e.write = 1'b1; e.writenum = rd; push(e, 1'b0);
         push(done, 1'b0);
      end else if (opc == 3'b101) begin
         e = idle; e.readnum = rn; e.loada = 1'b1; push(e, 1'b0);
         e = idle; e.readnum = rm; e.loadb = 1'b1; push(e, 1'b0);
         if (op == 2'b01) begin
            e = idle; e.loads = 1'b1; push(e, 1'b1);
         end else begin
            e = idle; e.loadc = 1'b1; push(e, 1'b1);
            e = idle; e.write = 1'b1; e.writenum = rd; push(e, 1'b0);
         end
         push(done, 1'b0);
      end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
         e = idle; e.err = 1'b1; push(e, 1'b0);
`else
         push(done, 1'b0);
`endif
      end
   endtask

   // Called at a negedge while in WAIT; returns just after the s-sampling edge
   task automatic start(input logic [15:0] ir, input bit do_load, input bit hold_s);
      in   = do_load ? ir : 16'($urandom);
      load = do_load;
      s    = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
      s    = hold_s;
      in   = 16'($urandom);
   endtask

   function automatic logic [15:0] rand_instr(input bit allow_illegal);
      int unsigned kind;
      logic [2:0] opc;
      logic [1:0] op;
      kind = $urandom_range(0, allow_illegal ? 6 : 5);
      case (kind)
         0: begin opc = 3'b110; op = 2'b10; end
         1: begin opc = 3'b110; op = 2'b00; end
         2: begin opc = 3'b101; op = 2'b11; end
         3: begin opc = 3'b101; op = 2'b00; end
         4: begin opc = 3'b101; op = 2'b01; end
         5: begin opc = 3'b101; op = 2'b10; end
         default: begin
            opc = 3'($urandom_range(0, 7));
            op  = 2'($urandom);
            if (opc == 3'b101) opc = 3'b111;
            if (opc == 3'b110) op = {op[1], 1'b1};
         end
      endcase
      return {opc, op, 11'($urandom)};
   endfunction

   task automatic test_reset();
      obs_t o, e;
      reset = 1'b1; s = 1'b0; load = 1'b0; in = 16'hFFFF;
      e = '0;
      e.w = 1'b1;
      repeat (2) begin
         @(negedge clk);
         o = sample();
         n_checks++;
         if (o !== e) begin
            n_errors++;
            $display("FAIL reset_hold: got %h expected %h", o, e);
         end
      end
      reset = 1'b0;
      @(negedge clk);
      o = sample();
      n_checks++;
      if (o !== e || sximm8 !== 16'h0 || sximm5 !== 16'h0) begin
         n_errors++;
         $display("FAIL reset_release: got %h imm8 %h imm5 %h expected %h imm 0", o, sximm8, sximm5, e);
      end
   endtask

   task automatic test_directed();
      logic [15:0] vecs[6];
      obs_t o;
      vecs = '{16'hD105, 16'hA0A1, 16'hA902, 16'hC0E3, 16'hB8E2, 16'hB0A1};
      foreach (vecs[i]) begin
         build_expect(vecs[i]);
         start(vecs[i], 1'b1, 1'b0);
         for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            o = sample();
            n_checks++;
            if ((o & msk_q[k]) !== (exp_q[k] & msk_q[k])) begin
               n_errors++;
               $display("FAIL directed %h step %0d: got %h expected %h mask %h",
                        vecs[i], k, o, exp_q[k], msk_q[k]);
            end
            if (k == 1) begin
               n_checks++;
               if ({sximm8, sximm5, shift, ALUop} !== imm_model(vecs[i])) begin
                  n_errors++;
                  $display("FAIL directed_imm %h: got %h expected %h", vecs[i],
                           {sximm8, sximm5, shift, ALUop}, imm_model(vecs[i]));
               end
            end
         end
      end
   endtask

   task automatic test_illegal();
      obs_t o;
      build_expect(16'hE000);
      start(16'hE000, 1'b1, 1'b1);
      for (int k = 0; k < exp_q.size(); k++) begin
         @(negedge clk);
         o = sample();
         n_checks++;
         if ((o & msk_q[k]) !== (exp_q[k] & msk_q[k])) begin
            n_errors++;
            $display("FAIL illegal step %0d: got %h expected %h", k, o, exp_q[k]);
         end
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      // Halt persists with s held high until reset
      repeat (4) begin
         @(negedge clk);
         o = sample();
         n_checks++;
         if (o !== exp_q[exp_q.size()-1]) begin
            n_errors++;
            $display("FAIL illegal_halt: got %h expected %h", o, exp_q[exp_q.size()-1]);
         end
      end
      s = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (err !== 1'b0 || w !== 1'b1) begin
         n_errors++;
         $display("FAIL illegal_reset: err %b w %b expected err 0 w 1", err, w);
      end
`else
      s = 1'b0;
`endif
   endtask

   task automatic test_reset_mid_instr();
      start(16'hA0A1, 1'b1, 1'b0);
      repeat (3) @(negedge clk);
      n_checks++;
      if (loadb !== 1'b1 || readnum !== 3'd1) begin
         n_errors++;
         $display("FAIL midreset_getb: loadb %b readnum %0d expected 1 1", loadb, readnum);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if ({write, loada, loadb, loadc, loads} !== 5'b0) begin
         n_errors++;
         $display("FAIL midreset_gate: strobes %b expected 00000", {write, loada, loadb, loadc, loads});
      end
      @(negedge clk);
      n_checks++;
      if (w !== 1'b1 || write !== 1'b0 || {sximm8, sximm5, shift, ALUop} !== 36'h0) begin
         n_errors++;
         $display("FAIL midreset_state: w %b write %b ir_fields %h expected w 1 write 0 fields 0",
                  w, write, {sximm8, sximm5, shift, ALUop});
      end
      reset = 1'b0;
      repeat (4) begin
         @(negedge clk);
         n_checks++;
         if (w !== 1'b1 || write !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_idle: w %b write %b expected w 1 write 0", w, write);
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] ir;
      bit allow_illegal;
      bit preload;
      obs_t o;
`ifdef CTRL_ILLEGAL_TRAP_EN
      allow_illegal = 1'b0;
`else
      allow_illegal = 1'b1;
`endif
      for (int n = 0; n < 40; n++) begin
         ir = rand_instr(allow_illegal);
         build_expect(ir);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         preload = 1'($urandom_range(0, 1));
         if (preload) begin
            in = ir; load = 1'b1; s = 1'b0;
            @(negedge clk);
            load = 1'b0;
         end
         start(ir, !preload, 1'b0);
         for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            o = sample();
            n_checks++;
            if ((o & msk_q[k]) !== (exp_q[k] & msk_q[k])) begin
               n_errors++;
               $display("FAIL random %h step %0d: got %h expected %h mask %h",
                        ir, k, o, exp_q[k], msk_q[k]);
            end
            if (k == 0) begin
               n_checks++;
               if ({sximm8, sximm5, shift, ALUop} !== imm_model(ir)) begin
                  n_errors++;
                  $display("FAIL random_imm %h: got %h expected %h", ir,
                           {sximm8, sximm5, shift, ALUop}, imm_model(ir));
               end
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] ir;
      obs_t o;
      ir = rand_instr(1'b0);
      in = ir; load = 1'b1; s = 1'b1;
      for (int n = 0; n < 6; n++) begin
         build_expect(ir);
         @(posedge clk);
         #1;
         in = 16'($urandom);
         for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            o = sample();
            n_checks++;
            if ((o & msk_q[k]) !== (exp_q[k] & msk_q[k])) begin
               n_errors++;
               $display("FAIL back_to_back %h step %0d: got %h expected %h mask %h",
                        ir, k, o, exp_q[k], msk_q[k]);
            end
         end
         ir = rand_instr(1'b0);
         in = ir;
      end
      s = 1'b0;
      load = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_illegal();
      test_reset_mid_instr();
      test_random();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit, checks %0d errors %0d", n_checks, n_errors);
      $fatal(1);
   end

endmodule
